// File: rtl/and8_pattern_gen.sv
// Stimulus driver and response checker for the AND reducer. It steps a pattern
// sequence, holds each pattern for DWELL cycles, then samples and checks the reducer output.
module and8_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DWELL = 100,
    parameter int ERRW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             and_in,
    output logic [WIDTH-1:0] pat_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FIN} state_t;

    localparam int CW = $clog2(DWELL);
    localparam int IW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};
    localparam logic [15:0]      MID16    = 16'h0012;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERRW-1:0]  err_q, err_d;
    logic [ERRW-1:0]  err_next;
    logic             is_last;

    // Mode 0 is handled by incrementing the pattern itself; this only supplies its first value.
    function automatic logic [WIDTH-1:0] seq_pattern(input logic [1:0] m, input logic [IW-1:0] idx);
        logic [WIDTH-1:0] p;
        p = '0;
        case (m)
            2'd0: p = '0;
            2'd1: begin
                p = ONES;
                for (int b = 0; b < WIDTH; b++)
                    if (idx != '0 && b == int'(idx) - 1) p[b] = 1'b0;
            end
            default: begin
                case (idx)
                    IW'(0):  p = '0;
                    IW'(1):  p = MID16[WIDTH-1:0];
                    default: p = ONES;
                endcase
            end
        endcase
        return p;
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pat_d    = pat_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        err_next = err_q;
        is_last  = 1'b0;

        case (mode_q)
            2'd0:    is_last = &pat_q;
            2'd1:    is_last = (idx_q == IW'(WIDTH));
            default: is_last = (idx_q == IW'(2));
        endcase

        if (and_in != &pat_q && err_q != {ERRW{1'b1}})
            err_next = err_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    pat_d   = seq_pattern(mode, '0);
                    idx_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == LAST_CNT)
                    state_d = CHECK;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            CHECK: begin
                err_d = err_next;
                if (is_last) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_next == '0);
                    pat_d   = '0;
                    state_d = FIN;
                end else begin
                    // Mode 0 leaves the index alone so it cannot wrap on long counts.
                    if (mode_q == 2'd0) begin
                        pat_d = pat_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        pat_d = seq_pattern(mode_q, idx_q + 1'b1);
                    end
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign pat_out   = pat_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_and8_pattern_gen.sv
// Directed bench for and8_pattern_gen with DWELL=4; a second instance with ERRW=4
// runs in lockstep to show counter saturation.
module tb_and8_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic       force_en;
    logic       force_val;

    logic [7:0] pat_out;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [7:0] pat_out4;
    logic       busy4, done4, pass4;
    logic [3:0] err4;
    logic       and_in, and_in4;

    int total;
    int bad;
    int c;
    int done_seen;

    logic [7:0] m2_pats [3];
    logic [7:0] m1_pats [9];

    assign and_in  = force_en ? force_val : &pat_out;
    assign and_in4 = force_en ? force_val : &pat_out4;

    and8_pattern_gen #(.WIDTH(8), .DWELL(4), .ERRW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .and_in(and_in),
        .pat_out(pat_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    and8_pattern_gen #(.WIDTH(8), .DWELL(4), .ERRW(4)) dut_e4 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .and_in(and_in4),
        .pat_out(pat_out4), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses start for one cycle; returns at the negedge of the first pattern cycle.
    task automatic applyStimulus(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m2_pats = '{8'h00, 8'h12, 8'hFF};
        m1_pats = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        rst_n = 1'b0; start = 1'b0; mode = 2'd0; force_en = 1'b0; force_val = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        checkOutput("rst_pat", 32'(pat_out), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_pass", 32'(pass), 32'h0);
        checkOutput("rst_err", 32'(err_count), 32'h0);

        $display("[TB] mode 2 ideal run");
        applyStimulus(2'd2);
        for (int k = 1; k <= 16; k++) begin
            if (k <= 15) checkOutput("m2_pat", 32'(pat_out), 32'(m2_pats[(k - 1) / 5]));
            checkOutput("m2_done", 32'(done), 32'(k == 16));
            checkOutput("m2_busy", 32'(busy), 32'(k != 16));
            if (k == 16) begin
                checkOutput("m2_pass", 32'(pass), 32'h1);
                checkOutput("m2_err", 32'(err_count), 32'h0);
                checkOutput("m2_fin_pat", 32'(pat_out), 32'h0);
            end
            step();
        end
        checkOutput("m2_idle_done", 32'(done), 32'h0);
        checkOutput("m2_pass_held", 32'(pass), 32'h1);

        $display("[TB] mode 1 ideal run with mode changed mid-run");
        applyStimulus(2'd1);
        mode = 2'd0;
        for (int k = 1; k <= 46; k++) begin
            if (k <= 45 && (k - 1) % 5 == 0)
                checkOutput("m1_pat", 32'(pat_out), 32'(m1_pats[(k - 1) / 5]));
            checkOutput("m1_done", 32'(done), 32'(k == 46));
            if (k == 46) begin
                checkOutput("m1_pass", 32'(pass), 32'h1);
                checkOutput("m1_err", 32'(err_count), 32'h0);
            end
            step();
        end

        $display("[TB] mode 0 with and_in stuck at 0");
        force_en = 1'b1; force_val = 1'b0;
        applyStimulus(2'd0);
        c = 0;
        while (busy && c < 2000) begin
            if (c == 825) checkOutput("m0_pat_a5", 32'(pat_out), 32'hA5);
            c++;
            step();
        end
        checkOutput("m0z_busy_len", 32'(c), 32'd1280);
        checkOutput("m0z_done", 32'(done), 32'h1);
        checkOutput("m0z_err", 32'(err_count), 32'h1);
        checkOutput("m0z_pass", 32'(pass), 32'h0);
        checkOutput("m0z_err4", 32'(err4), 32'h1);
        step();

        $display("[TB] mode 0 with and_in stuck at 1");
        force_val = 1'b1;
        applyStimulus(2'd0);
        c = 0;
        while (!done && c < 2000) begin
            c++;
            step();
        end
        checkOutput("m0o_done_cycle", 32'(c), 32'd1280);
        checkOutput("m0o_err", 32'(err_count), 32'd255);
        checkOutput("m0o_err4_sat", 32'(err4), 32'd15);
        checkOutput("m0o_pass", 32'(pass), 32'h0);
        step();

        $display("[TB] reset during second pattern");
        applyStimulus(2'd2);
        for (int k = 1; k < 7; k++) step();
        checkOutput("rm_pat2", 32'(pat_out), 32'h12);
        checkOutput("rm_err_pre", 32'(err_count), 32'h1);
        rst_n = 1'b0;
        step();
        checkOutput("rm_pat", 32'(pat_out), 32'h0);
        checkOutput("rm_busy", 32'(busy), 32'h0);
        checkOutput("rm_err", 32'(err_count), 32'h0);
        checkOutput("rm_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        force_en = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) done_seen++;
            step();
        end
        checkOutput("rm_no_done", 32'(done_seen), 32'h0);
        applyStimulus(2'd2);
        c = 1;
        while (!done && c < 100) begin
            c++;
            step();
        end
        checkOutput("rm_rerun_cycle", 32'(c), 32'd16);
        checkOutput("rm_rerun_pass", 32'(pass), 32'h1);
        step();

        $display("[TB] start while busy and in FIN");
        applyStimulus(2'd2);
        step(); step();
        start = 1'b1; mode = 2'd1;
        step();
        start = 1'b0; mode = 2'd2;
        checkOutput("ig_pat4", 32'(pat_out), 32'h00);
        step(); step();
        checkOutput("ig_pat6", 32'(pat_out), 32'h12);
        for (int k = 0; k < 5; k++) step();
        checkOutput("ig_pat11", 32'(pat_out), 32'hFF);
        for (int k = 0; k < 5; k++) step();
        checkOutput("ig_done16", 32'(done), 32'h1);
        start = 1'b1; mode = 2'd1;
        step();
        start = 1'b0;
        checkOutput("ig_fin_busy", 32'(busy), 32'h0);
        checkOutput("ig_fin_pat", 32'(pat_out), 32'h0);
        checkOutput("ig_fin_pass", 32'(pass), 32'h1);
        step();
        checkOutput("ig_idle_busy", 32'(busy), 32'h0);
        applyStimulus(2'd1);
        checkOutput("ns_busy", 32'(busy), 32'h1);
        checkOutput("ns_pass_clr", 32'(pass), 32'h0);
        checkOutput("ns_pat", 32'(pat_out), 32'hFF);
        c = 1;
        while (!done && c < 200) begin
            c++;
            step();
        end
        checkOutput("ns_done_cycle", 32'(c), 32'd46);
        checkOutput("ns_pass", 32'(pass), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
